// File: rtl/ltc_pkg.sv
// Shared constants for the line-clock event timer: CSR bit positions, I/O page address
// and the readback packing helper.
package ltc_pkg;

    localparam int unsigned CSR_MON_BIT = 7;
    localparam int unsigned CSR_IE_BIT  = 6;
    localparam int unsigned CSR_ST_BIT  = 0;

    localparam logic [15:0] CSR_ADDR = 16'o177546;

    typedef logic [15:0] csr_word_t;

    function automatic csr_word_t csr_pack(input logic mon, input logic ie, input logic st);
        csr_word_t word;
        word              = '0;
        word[CSR_MON_BIT] = mon;
        word[CSR_IE_BIT]  = ie;
        word[CSR_ST_BIT]  = st;
        return word;
    endfunction

endpackage

// File: rtl/ltc_event_timer_if.sv
// Wishbone slave port of the line-clock CSR; the strobe arrives already decoded for the CSR address.
interface ltc_event_timer_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_sel_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/btn_debounce.sv
// Tick-sampled button debouncer that toggles its output once per accepted press.
module btn_debounce #(
    parameter int   DEB_STAGES = 2,
    parameter logic INIT       = 1'b1
) (
    input  logic clk_p,
    input  logic rst_n,
    input  logic sample_en,
    input  logic btn,
    output logic state
);

    if (DEB_STAGES < 2) begin : g_bad_stages
        $error("btn_debounce: DEB_STAGES must be at least 2");
    end

    logic [DEB_STAGES-1:0] shift;
    logic [DEB_STAGES-1:0] shift_next;
    logic                  armed;

    assign shift_next = {shift[DEB_STAGES-2:0], btn};

    // Armed blocks repeated toggles while the button stays held; only a full release re-arms.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
            armed <= 1'b0;
            state <= INIT;
        end else if (sample_en) begin
            shift <= shift_next;
            if ((&shift_next) && !armed) begin
                state <= ~state;
                armed <= 1'b1;
            end else if (shift_next == '0) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ltc_event_timer.sv
// Line-clock event source: periodic tick, stretched CPU event pulse, debounced enable button
// and a KW11-L style CSR on Wishbone.
module ltc_event_timer
    import ltc_pkg::*;
#(
    parameter int   CLK_HZ     = 100_000_000,
    parameter int   TICK_HZ    = 50,
    parameter int   PULSE_CYC  = 1,
    parameter int   DEB_STAGES = 2,
    parameter logic TIMER_INIT = 1'b1,
    parameter logic IE_INIT    = 1'b1
) (
    input  logic                 clk_p,
    input  logic                 rst_n,
    ltc_event_timer_if.slave     wb,
    input  logic                 timer_button,
    output logic                 timer_status,
    output logic                 tick_o,
    output logic                 evnt_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(PULSE_CYC + 1);

    if (DIV < 2) begin : g_bad_div
        $error("ltc_event_timer: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (PULSE_CYC < 1 || PULSE_CYC >= DIV) begin : g_bad_pulse
        $error("ltc_event_timer: PULSE_CYC must satisfy 1 <= PULSE_CYC < DIV");
    end

    logic [CW-1:0] cnt;
    logic [PW-1:0] pulse_cnt;
    logic          mon;
    logic          ie;
    logic          access;
    logic          wr_low;
    logic          pulse_start;
    logic          unused_bits;

    assign access      = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign wr_low      = access & wb.wb_we_i & wb.wb_sel_i[0];
    assign pulse_start = tick_o & timer_status & ie;
    assign unused_bits = ^{wb.wb_sel_i[1], wb.wb_dat_i[15:8], wb.wb_dat_i[5:0]};

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= (cnt == CW'(DIV - 1));
            cnt    <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
        end
    end

    // The pulse runs to completion once started, whatever happens to the enables meanwhile.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            evnt_o    <= 1'b0;
            pulse_cnt <= '0;
        end else if (pulse_start) begin
            evnt_o    <= 1'b1;
            pulse_cnt <= PW'(PULSE_CYC - 1);
        end else if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - 1'b1;
        end else begin
            evnt_o <= 1'b0;
        end
    end

    // Readback captures the pre-write value; a tick beats a clearing write on MON.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
            mon         <= 1'b0;
            ie          <= IE_INIT;
        end else begin
            wb.wb_ack_o <= access;
            if (access) begin
                wb.wb_dat_o <= csr_pack(mon, ie, timer_status);
            end
            if (wr_low) begin
                ie <= wb.wb_dat_i[CSR_IE_BIT];
            end
            if (tick_o) begin
                mon <= 1'b1;
            end else if (wr_low && !wb.wb_dat_i[CSR_MON_BIT]) begin
                mon <= 1'b0;
            end
        end
    end

    btn_debounce #(
        .DEB_STAGES (DEB_STAGES),
        .INIT       (TIMER_INIT)
    ) u_debounce (
        .clk_p     (clk_p),
        .rst_n     (rst_n),
        .sample_en (tick_o),
        .btn       (timer_button),
        .state     (timer_status)
    );

endmodule

// File: tb/tb_ltc_event_timer.sv
// Directed bench for ltc_event_timer with DIV=10, PULSE_CYC=3, DEB_STAGES=2; CSR reads are
// checked through an expected-data queue.
module tb_ltc_event_timer;

    logic clk_p;
    logic rst_n;
    logic timer_button;
    logic timer_status;
    logic tick_o;
    logic evnt_o;

    int checks = 0;
    int errors = 0;
    int cycle_no;

    logic [15:0] exp_q[$];

    ltc_event_timer_if bus ();

    ltc_event_timer #(
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .PULSE_CYC  (3),
        .DEB_STAGES (2),
        .TIMER_INIT (1'b1),
        .IE_INIT    (1'b1)
    ) dut (
        .clk_p        (clk_p),
        .rst_n        (rst_n),
        .wb           (bus.slave),
        .timer_button (timer_button),
        .timer_status (timer_status),
        .tick_o       (tick_o),
        .evnt_o       (evnt_o)
    );

    initial begin
        clk_p = 1'b0;
        forever #5 clk_p = ~clk_p;
    end

    // Edges since the last reset release; ticks are expected on every tenth one.
    always @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) cycle_no <= 0;
        else        cycle_no <= cycle_no + 1;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    always @(posedge clk_p) begin
        #1;
        if (rst_n === 1'b1) begin
            checkOutput("tick", {15'b0, tick_o},
                        {15'b0, (cycle_no != 0) && (cycle_no % 10 == 0)});
        end
    end

    task automatic waitCycle(input int n);
        int guard;
        guard = 0;
        while (cycle_no != n && guard < 1000) begin
            @(posedge clk_p);
            #1;
            guard++;
        end
        if (cycle_no != n) begin
            checkOutput("wait_timeout", cycle_no[15:0], n[15:0]);
        end
    endtask

    // One Wishbone transfer; entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input logic we, input logic [1:0] sel, input logic [15:0] dat,
                                 input logic [15:0] exp_rd);
        logic        got;
        logic [15:0] expv;
        if (!we) exp_q.push_back(exp_rd);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_sel_i = sel;
        bus.wb_dat_i = dat;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk_p);
            #1;
            if (bus.wb_ack_o === 1'b1) got = 1'b1;
        end
        checkOutput("ack_seen", {15'b0, got}, 16'h0001);
        if (got && !we) begin
            expv = exp_q.pop_front();
            checkOutput("read_data", bus.wb_dat_o, expv);
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        @(posedge clk_p);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_evnt"}, {15'b0, evnt_o}, 16'h0000);
        checkOutput({tag, "_tick"}, {15'b0, tick_o}, 16'h0000);
        checkOutput({tag, "_ack"}, {15'b0, bus.wb_ack_o}, 16'h0000);
        checkOutput({tag, "_dat"}, bus.wb_dat_o, 16'h0000);
        checkOutput({tag, "_status"}, {15'b0, timer_status}, 16'h0001);
    endtask

    initial begin
        rst_n        = 1'b1;
        timer_button = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 2'b00;
        bus.wb_dat_i = 16'h0000;
        #2 rst_n = 1'b0;
        #5;
        checkResetOutputs("reset");
        @(negedge clk_p);
        rst_n = 1'b1;

        $display("[TB] step 1: free-running ticks and event pulses");
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk_p);
            #1;
            checkOutput("evnt_run", {15'b0, evnt_o},
                        {15'b0, (cycle_no > 10) && (cycle_no % 10 >= 1) && (cycle_no % 10 <= 3)});
        end

        $display("[TB] step 2: clear IE and MON, events stop");
        applyStimulus(1'b1, 2'b01, 16'o000000, 16'h0000);
        applyStimulus(1'b0, 2'b01, 16'h0000, 16'o000001);
        waitCycle(40);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_p);
            #1;
            checkOutput("evnt_gated", {15'b0, evnt_o}, 16'h0000);
        end
        applyStimulus(1'b0, 2'b01, 16'h0000, 16'o000201);

        $display("[TB] step 3: clearing write against a tick");
        waitCycle(50);
        applyStimulus(1'b1, 2'b01, 16'o000000, 16'h0000);
        applyStimulus(1'b0, 2'b01, 16'h0000, 16'o000201);
        applyStimulus(1'b1, 2'b01, 16'o000000, 16'h0000);
        applyStimulus(1'b0, 2'b01, 16'h0000, 16'o000001);
        applyStimulus(1'b1, 2'b01, 16'o000100, 16'h0000);
        waitCycle(62);
        applyStimulus(1'b0, 2'b01, 16'h0000, 16'o000301);

        $display("[TB] step 4: held button toggles once, second press toggles back");
        timer_button = 1'b1;
        waitCycle(72);
        checkOutput("status_first_sample", {15'b0, timer_status}, 16'h0001);
        waitCycle(82);
        checkOutput("status_toggled", {15'b0, timer_status}, 16'h0000);
        checkOutput("evnt_old_status", {15'b0, evnt_o}, 16'h0001);
        waitCycle(92);
        checkOutput("evnt_disabled", {15'b0, evnt_o}, 16'h0000);
        waitCycle(112);
        checkOutput("status_held", {15'b0, timer_status}, 16'h0000);
        timer_button = 1'b0;
        waitCycle(132);
        timer_button = 1'b1;
        waitCycle(142);
        checkOutput("status_repress_1", {15'b0, timer_status}, 16'h0000);
        waitCycle(152);
        checkOutput("status_repress_2", {15'b0, timer_status}, 16'h0001);
        timer_button = 1'b0;

        $display("[TB] step 5: one-tick glitch and high-byte write");
        waitCycle(172);
        timer_button = 1'b1;
        waitCycle(182);
        timer_button = 1'b0;
        checkOutput("glitch_1", {15'b0, timer_status}, 16'h0001);
        waitCycle(192);
        checkOutput("glitch_2", {15'b0, timer_status}, 16'h0001);
        applyStimulus(1'b1, 2'b10, 16'o000000, 16'h0000);
        applyStimulus(1'b0, 2'b01, 16'h0000, 16'o000301);

        $display("[TB] step 6: reset during pulse and during transfers");
        waitCycle(201);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        @(posedge clk_p);
        #1;
        checkOutput("pre_reset_evnt", {15'b0, evnt_o}, 16'h0001);
        checkOutput("pre_reset_ack", {15'b0, bus.wb_ack_o}, 16'h0001);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort1");
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        @(negedge clk_p);
        rst_n = 1'b1;

        timer_button = 1'b1;
        waitCycle(22);
        checkOutput("status_before_rst", {15'b0, timer_status}, 16'h0000);
        timer_button = 1'b0;
        applyStimulus(1'b1, 2'b01, 16'o000200, 16'h0000);
        applyStimulus(1'b0, 2'b01, 16'h0000, 16'o000200);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort2");
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        @(negedge clk_p);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_p);
            #1;
            checkOutput("no_ack_after_abort", {15'b0, bus.wb_ack_o}, 16'h0000);
        end
        applyStimulus(1'b0, 2'b01, 16'h0000, 16'o000101);

        checkOutput("queue_empty", exp_q.size() == 0 ? 16'h0001 : 16'h0000, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
